// File: rtl/mod_add_ctrl.sv
// Sequencer for the shared N+1-bit adder: computes (a+b) mod m or (a-b) mod m in one or two adder passes.
// Optional MOD_ADD_TIMEOUT_EN adds an error output and a bounded wait on add_done.
module mod_add_ctrl #(
  parameter int N              = 512,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         add_start,
  output logic         add_subtract,
  output logic [N:0]   add_in_a,
  output logic [N:0]   add_in_b,
  input  logic [N+1:0] add_result,
  input  logic         add_done
`ifdef MOD_ADD_TIMEOUT_EN
  ,
  output logic         error
`endif
);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, FIN} state_t;

  state_t         state_q, state_d;
  logic           sub_q, sub_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   s1_q, s1_d;
  logic [N-1:0]   result_q, result_d;
  logic           add_sub_q, add_sub_d;
  logic [N:0]     add_a_q, add_a_d;
  logic [N:0]     add_b_q, add_b_d;

`ifdef MOD_ADD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timed_out;

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign error     = err_q;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sub_q     <= 1'b0;
      m_q       <= '0;
      s1_q      <= '0;
      result_q  <= '0;
      add_sub_q <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
`ifdef MOD_ADD_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      m_q       <= m_d;
      s1_q      <= s1_d;
      result_q  <= result_d;
      add_sub_q <= add_sub_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
`ifdef MOD_ADD_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    m_d       = m_q;
    s1_d      = s1_q;
    result_d  = result_q;
    add_sub_d = add_sub_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_start = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
`ifdef MOD_ADD_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          sub_d     = subtract;
          m_d       = in_m;
          add_a_d   = {1'b0, in_a};
          add_b_d   = {1'b0, in_b};
          add_sub_d = subtract;
          state_d   = REQ1;
`ifdef MOD_ADD_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end

      REQ1, REQ2: begin
        add_start = 1'b1;
        state_d   = (state_q == REQ1) ? WAIT1 : WAIT2;
`ifdef MOD_ADD_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      WAIT1: begin
        if (add_done) begin
          s1_d = add_result[N-1:0];
          if (sub_q && !add_result[N+1]) begin
            result_d = add_result[N-1:0];
            state_d  = FIN;
          end else begin
            // Bit N carries the a+b overflow (or the borrow of a-b) into the correction pass.
            add_a_d   = add_result[N:0];
            add_b_d   = {1'b0, m_q};
            add_sub_d = !sub_q;
            state_d   = REQ2;
          end
        end
`ifdef MOD_ADD_TIMEOUT_EN
        else if (timed_out) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      WAIT2: begin
        if (add_done) begin
          // A negative s1-m means the sum was already reduced.
          if (!sub_q && add_result[N+1]) begin
            result_d = s1_q;
          end else begin
            result_d = add_result[N-1:0];
          end
          state_d = FIN;
        end
`ifdef MOD_ADD_TIMEOUT_EN
        else if (timed_out) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign result       = result_q;
  assign add_subtract = add_sub_q;
  assign add_in_a     = add_a_q;
  assign add_in_b     = add_b_q;

endmodule

// File: tb/tb_mod_add_ctrl.sv
// Directed bench for mod_add_ctrl with a behavioural adder responder of configurable latency.
module tb_mod_add_ctrl;
  localparam int N = 512;

  logic         clk = 1'b0;
  logic         resetn, start, subtract;
  logic [N-1:0] in_a, in_b, in_m;
  logic [N-1:0] result;
  logic         done, busy, add_start, add_subtract;
  logic [N:0]   add_in_a, add_in_b;
  logic [N+1:0] add_result;
  logic         add_done;
`ifdef MOD_ADD_TIMEOUT_EN
  logic         error;
`endif

  int checks = 0;
  int errors = 0;

  int           lat_l   = 3;
  bit           resp_en = 1'b1;
  int           rem     = 0;
  int           nstarts = 0;
  logic [N+1:0] res_pend;
  logic         last_sub;
  logic [N:0]   last_a;

  always #5 clk = ~clk;

  mod_add_ctrl #(.N(N), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .subtract     (subtract),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .result       (result),
    .done         (done),
    .busy         (busy),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_in_a     (add_in_a),
    .add_in_b     (add_in_b),
    .add_result   (add_result),
    .add_done     (add_done)
`ifdef MOD_ADD_TIMEOUT_EN
    ,
    .error        (error)
`endif
  );

  // Adder responder: add_done pulses lat_l cycles after each add_start.
  initial begin
    add_done   = 1'b0;
    add_result = '0;
    res_pend   = '0;
    last_sub   = 1'b0;
    last_a     = '0;
    forever begin
      @(negedge clk);
      add_done = 1'b0;
      if (!resetn) begin
        rem = 0;
      end else begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) begin
            add_done   = 1'b1;
            add_result = res_pend;
          end
        end
        if (add_start === 1'b1) begin
          nstarts++;
          last_sub = add_subtract;
          last_a   = add_in_a;
          res_pend = add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                  : ({1'b0, add_in_a} + {1'b0, add_in_b});
          if (resp_en) rem = lat_l;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [N+1:0] obs, input logic [N+1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] m, input logic sub);
    @(negedge clk);
    nstarts  = 0;
    in_a     = a;
    in_b     = b;
    in_m     = m;
    subtract = sub;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the first cycle after the start edge; returns edges from start edge to done.
  task automatic wait_done(input string tag, output int lat);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    lat = k + 1;
    $display("op %s: result=%0h latency=%0d adder_starts=%0d", tag, result, lat, nstarts);
  endtask

  initial begin
    int lat;
    int k;
    bit saw_done;
    logic [N-1:0] all1;
    all1     = '1;
    resetn   = 1'b0;
    start    = 1'b0;
    subtract = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_m     = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_add_subtract", add_subtract, 0);
    chk("rst_add_in_a", add_in_a, 0);
    chk("rst_add_in_b", add_in_b, 0);
    resetn = 1'b1;

    // 7+9 mod 13, L=3: two passes, second is a subtract
    lat_l = 3;
    launch(7, 9, 13, 1'b0);
    chk("add1_busy", busy, 1);
    chk("add1_add_start", add_start, 1);
    wait_done("add1", lat);
    chk("add1_result", result, 3);
    chk("add1_latency", lat, 9);
    chk("add1_nstarts", nstarts, 2);
    chk("add1_second_sub", last_sub, 1);
    @(negedge clk);
    chk("add1_busy_after", busy, 0);

    // 3+4 mod 13: s1-m negative, keep s1
    launch(3, 4, 13, 1'b0);
    wait_done("add2", lat);
    chk("add2_result", result, 7);

    // 3-9 mod 13, L=2: negative difference, corrected by +m
    lat_l = 2;
    launch(3, 9, 13, 1'b1);
    wait_done("sub1", lat);
    chk("sub1_result", result, 7);
    chk("sub1_nstarts", nstarts, 2);
    chk("sub1_second_sub", last_sub, 0);
    chk("sub1_latency", lat, 7);

    // 9-3 mod 13: single pass
    launch(9, 3, 13, 1'b1);
    wait_done("sub2", lat);
    chk("sub2_result", result, 6);
    chk("sub2_nstarts", nstarts, 1);
    chk("sub2_latency", lat, 4);

    // Full-width: carry into bit N must reach the second pass
    lat_l = 1;
    launch(all1 - 1, all1 - 1, all1, 1'b0);
    wait_done("wide", lat);
    chk("wide_result", result, all1 - 2);
    chk("wide_carry", last_a[N], 1);
    chk("wide_latency", lat, 5);

    launch(12, 1, 13, 1'b0);
    wait_done("zero", lat);
    chk("zero_result", result, 0);

    // start during WAIT1 is ignored
    lat_l = 3;
    launch(7, 9, 13, 1'b0);
    @(negedge clk);
    in_a = 5; in_b = 5; subtract = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", lat);
    chk("ignore_result", result, 3);
    chk("ignore_nstarts", nstarts, 2);

    // Reset during WAIT2 aborts without done
    launch(7, 9, 13, 1'b0);
    k = 0;
    while (nstarts < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_req2", nstarts, 2);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_result", result, 0);
    chk("abort_busy", busy, 0);
    chk("abort_add_start", add_start, 0);
    chk("abort_add_in_a", add_in_a, 0);
    chk("abort_add_in_b", add_in_b, 0);
    chk("abort_add_subtract", add_subtract, 0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    $display("op abort: reset in WAIT2, done_seen=%0d", saw_done);
    launch(3, 4, 13, 1'b0);
    wait_done("after_abort", lat);
    chk("after_abort_result", result, 7);

`ifdef MOD_ADD_TIMEOUT_EN
    resp_en = 1'b0;
    launch(7, 9, 13, 1'b0);
    wait_done("timeout", lat);
    chk("timeout_result", result, 0);
    chk("timeout_error", error, 1);
    chk("timeout_latency", lat, 10);
    resp_en = 1'b1;
    launch(7, 9, 13, 1'b0);
    chk("timeout_error_cleared", error, 0);
    wait_done("post_timeout", lat);
    chk("post_timeout_result", result, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
